// File: rtl/spim_shift.sv
// Byte-level SPI shift engine: one write/read/dummy op per start, 1/2/4 lines, programmable mode and divider.
// Optional `define SPIM_SHIFT_LSBF_EN enables the LSB-first (i_lsbf) bit-order reversal.
module spim_shift (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr_n,
  input  logic [1:0] i_ckmod,
  input  logic [7:0] i_ckdiv,
  input  logic       i_lsbf,
  input  logic [1:0] i_boper,
  input  logic [1:0] i_bmode,
  input  logic [7:0] i_tbyte,
  input  logic [4:0] i_dummy,
  output logic [7:0] o_rbyte,
  output logic       o_bdone,
  output logic       o_busy,
  output logic       o_spi_ck,
  input  logic [3:0] i_spi_di,
  output logic [3:0] o_spi_do,
  output logic [3:0] o_spi_oe
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_DUMMY = 2'd3;

  localparam logic [1:0] M_SINGLE = 2'd1;
  localparam logic [1:0] M_DUAL   = 2'd2;
  localparam logic [1:0] M_QUAD   = 2'd3;

  function automatic logic [3:0] f_tx_bits(input logic [7:0] sh, input logic [1:0] mode);
    case (mode)
      M_QUAD:  return sh[7:4];
      M_DUAL:  return {2'b00, sh[7:6]};
      default: return {3'b000, sh[7]};
    endcase
  endfunction

  function automatic logic [7:0] f_tx_shift(input logic [7:0] sh, input logic [1:0] mode);
    case (mode)
      M_QUAD:  return {sh[3:0], 4'h0};
      M_DUAL:  return {sh[5:0], 2'b00};
      default: return {sh[6:0], 1'b0};
    endcase
  endfunction

  function automatic logic [7:0] f_rx_shift(input logic [7:0] rx, input logic [3:0] di,
                                            input logic [1:0] mode);
    case (mode)
      M_QUAD:  return {rx[3:0], di};
      M_DUAL:  return {rx[5:0], di[1:0]};
      default: return {rx[6:0], di[1]};
    endcase
  endfunction

  function automatic logic [3:0] f_oe_write(input logic [1:0] mode);
    case (mode)
      M_QUAD:  return 4'b1111;
      M_DUAL:  return 4'b0011;
      default: return 4'b0001;
    endcase
  endfunction

`ifdef SPIM_SHIFT_LSBF_EN
  // LSB-first reverses the order of k-bit groups, keeping each group's internal order.
  function automatic logic [7:0] f_grp_rev(input logic [7:0] b, input logic [1:0] mode);
    case (mode)
      M_QUAD:  return {b[3:0], b[7:4]};
      M_DUAL:  return {b[1:0], b[3:2], b[5:4], b[7:6]};
      default: return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
    endcase
  endfunction
`endif

  logic [1:0] r_state;
  logic [1:0] r_op;
  logic [1:0] r_mode;
  logic       r_cpha;
  logic [7:0] r_ckdiv;
  logic [7:0] r_cnt;
  logic [5:0] r_tog;
  logic [7:0] r_sh;
  logic [7:0] r_rx;
  logic [7:0] r_rbyte;
  logic       r_bdone;
  logic       r_busy;
  logic       r_spi_ck;
  logic [3:0] r_spi_do;
  logic [3:0] r_spi_oe;
`ifdef SPIM_SHIFT_LSBF_EN
  logic       r_lsbf;
`endif

  logic [1:0] w_mode;
  logic [5:0] w_tog;
  logic [7:0] w_tx;
  logic [7:0] w_rx_final;
  logic       w_lead;
  logic       w_sample;
  logic       w_shift_out;

  assign w_mode = (i_bmode == 2'd0) ? M_SINGLE : i_bmode;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_tog = 6'd0;
    if (i_boper == OP_DUMMY) begin
      w_tog = {i_dummy, 1'b0};
    end else begin
      case (w_mode)
        M_QUAD:  w_tog = 6'd4;
        M_DUAL:  w_tog = 6'd8;
        default: w_tog = 6'd16;
      endcase
    end
  end

`ifdef SPIM_SHIFT_LSBF_EN
  assign w_tx       = i_lsbf ? f_grp_rev(i_tbyte, w_mode) : i_tbyte;
  assign w_rx_final = r_lsbf ? f_grp_rev(r_rx, r_mode) : r_rx;
`else
  logic w_unused_lsbf;
  assign w_unused_lsbf = i_lsbf;
  assign w_tx          = i_tbyte;
  assign w_rx_final    = r_rx;
`endif

  // Remaining toggle count is even before a leading edge, odd before a trailing edge.
  assign w_lead      = ~r_tog[0];
  assign w_sample    = w_lead ^ r_cpha;
  assign w_shift_out = (r_op == OP_WRITE) &&
                       (r_cpha ? w_lead : (!w_lead && (r_tog != 6'd1)));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= OP_NONE;
      r_mode   <= M_SINGLE;
      r_cpha   <= 1'b0;
      r_ckdiv  <= 8'd0;
      r_cnt    <= 8'd0;
      r_tog    <= 6'd0;
      r_sh     <= 8'd0;
      r_rx     <= 8'd0;
      r_rbyte  <= 8'd0;
      r_bdone  <= 1'b0;
      r_busy   <= 1'b0;
      r_spi_ck <= 1'b0;
      r_spi_do <= 4'd0;
      r_spi_oe <= 4'd0;
`ifdef SPIM_SHIFT_LSBF_EN
      r_lsbf   <= 1'b0;
`endif
    end else if (!i_clr_n) begin
      r_state  <= S_IDLE;
      r_rbyte  <= 8'd0;
      r_bdone  <= 1'b0;
      r_busy   <= 1'b0;
      r_spi_ck <= i_ckmod[1];
      r_spi_do <= 4'd0;
      r_spi_oe <= 4'd0;
    end else begin
      r_bdone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_spi_ck <= i_ckmod[1];
          if (i_boper != OP_NONE) begin
            r_state <= S_SHIFT;
            r_busy  <= 1'b1;
            r_op    <= i_boper;
            r_mode  <= w_mode;
            r_cpha  <= i_ckmod[0];
            r_ckdiv <= i_ckdiv;
            r_cnt   <= i_ckdiv;
            r_tog   <= w_tog;
            r_rx    <= 8'd0;
`ifdef SPIM_SHIFT_LSBF_EN
            r_lsbf  <= i_lsbf;
`endif
            case (i_boper)
              OP_WRITE: begin
                r_spi_oe <= f_oe_write(w_mode);
                if (!i_ckmod[0]) begin
                  r_spi_do <= f_tx_bits(w_tx, w_mode);
                  r_sh     <= f_tx_shift(w_tx, w_mode);
                end else begin
                  r_spi_do <= 4'd0;
                  r_sh     <= w_tx;
                end
              end
              OP_READ: begin
                // Single-line read holds MOSI high while the slave drives MISO.
                r_spi_oe <= (w_mode == M_SINGLE) ? 4'b0001 : 4'b0000;
                r_spi_do <= (w_mode == M_SINGLE) ? 4'b0001 : 4'b0000;
              end
              default: begin
                r_spi_oe <= 4'b0000;
                r_spi_do <= 4'b0000;
              end
            endcase
          end
        end

        S_SHIFT: begin
          if (r_tog == 6'd0) begin
            r_state <= S_DONE;
          end else if (r_cnt == 8'd0) begin
            r_spi_ck <= ~r_spi_ck;
            r_cnt    <= r_ckdiv;
            r_tog    <= r_tog - 6'd1;
            if (w_sample) begin
              r_rx <= f_rx_shift(r_rx, i_spi_di, r_mode);
            end
            if (w_shift_out) begin
              r_spi_do <= f_tx_bits(r_sh, r_mode);
              r_sh     <= f_tx_shift(r_sh, r_mode);
            end
            if (r_tog == 6'd1) begin
              r_state <= S_DONE;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_bdone <= 1'b1;
          if (r_op == OP_READ) begin
            r_rbyte <= w_rx_final;
          end
          if (r_op != OP_WRITE) begin
            r_spi_oe <= 4'b0000;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rbyte  = r_rbyte;
  assign o_bdone  = r_bdone;
  assign o_busy   = r_busy;
  assign o_spi_ck = r_spi_ck;
  assign o_spi_do = r_spi_do;
  assign o_spi_oe = r_spi_oe;

endmodule
